mem_stage: RTL

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM register outputs and performs loads and stores through a byte-wide request/acknowledge port to the memory controller. Each access is sequenced as 1, 2 or 4 byte transfers, and the stage holds the upstream pipeline with a stall request while the access is in progress. Non-memory instructions pass straight through to MEM/WB.

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the five-stage RISC-V pipeline. Loads and stores are
// performed as a sequence of 1, 2 or 4 byte transfers over a byte-wide
// request/acknowledge port. While an access is in progress the stage holds the
// upstream pipeline with stallreq_o. Non-memory instructions pass straight
// through to MEM/WB with zero latency.
//
// Ports
//   clk, rst          pipeline clock (rising edge), async active-low reset
//   wd_i, wreg_i      destination register / write enable from EX/MEM
//   wdata_i           ALU result, or rs2 value for stores
//   opcode_i, op_i    RISC-V opcode; op_i[2:0] carries funct3
//   mem_addr_i        effective address of the load/store
//   mem_req_o         byte transfer request
//   mem_we_o          1 = write byte, 0 = read byte
//   mem_a_o           byte address
//   mem_wbyte_o       byte to write
//   mem_ack_i         transfer completes this cycle
//   mem_rbyte_i       read byte, valid with mem_ack_i
//   stallreq_o        stall request to the pipeline controller
//   wd_o, wreg_o,
//   wdata_o           results to MEM/WB
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  opcode_i,
    input  logic [7:0]  op_i,
    input  logic [31:0] mem_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_wbyte_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rbyte_i,
    output logic        stallreq_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [1:0]  k;        // index of the byte currently being transferred
    logic [31:0] asm_q;    // load assembly register

    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic [1:0]  k_last;   // n-1
    logic [31:0] load_data;
    logic        unused_op;

    assign funct3    = op_i[2:0];
    assign unused_op = ^op_i[7:3];

    assign is_load  = (opcode_i == OPC_LOAD) &&
                      (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign is_store = (opcode_i == OPC_STORE) &&
                      (funct3 inside {3'b000, 3'b001, 3'b010});
    assign is_mem   = is_load || is_store;

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a variable unassigned (which would infer a latch).
    always_comb begin
        k_last    = 2'd3;
        load_data = asm_q;
        unique case (funct3[1:0])
            2'b00:   k_last = 2'd0;
            2'b01:   k_last = 2'd1;
            default: k_last = 2'd3;
        endcase
        case (funct3)
            3'b000:  load_data = {{24{asm_q[7]}}, asm_q[7:0]};
            3'b001:  load_data = {{16{asm_q[15]}}, asm_q[15:0]};
            3'b100:  load_data = {24'd0, asm_q[7:0]};
            3'b101:  load_data = {16'd0, asm_q[15:0]};
            default: load_data = asm_q;
        endcase
    end

    // Outputs are decoded from the state and the (stable) EX/MEM inputs. They
    // are gated by rst so an access is abandoned in the very cycle reset hits.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_a_o     = 32'd0;
        mem_wbyte_o = 8'd0;
        stallreq_o  = 1'b0;
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        if (rst) begin
            wd_o = wd_i;
            if (!is_mem) begin
                wreg_o  = wreg_i;
                wdata_o = wdata_i;
            end else if (state == DONE) begin
                // Stores leave wreg_o/wdata_o at 0.
                if (is_load) begin
                    wreg_o  = wreg_i;
                    wdata_o = load_data;
                end
            end else begin
                // IDLE with a memory op already issues byte 0 (k is 0 there).
                mem_req_o   = 1'b1;
                stallreq_o  = 1'b1;
                mem_we_o    = is_store;
                mem_a_o     = mem_addr_i + {30'd0, k};
                mem_wbyte_o = wdata_i[{k, 3'b000} +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            k     <= 2'd0;
            asm_q <= 32'd0;
        end else begin
            unique case (state)
                IDLE, BUSY: begin
                    if (!is_mem) begin
                        state <= IDLE;
                        k     <= 2'd0;
                    end else if (mem_ack_i) begin
                        // mem_req_o is high here, so an ack completes byte k.
                        if (is_load) asm_q[{k, 3'b000} +: 8] <= mem_rbyte_i;
                        if (k == k_last) begin
                            state <= DONE;
                            k     <= 2'd0;
                        end else begin
                            state <= BUSY;
                            k     <= k + 2'd1;
                        end
                    end else begin
                        state <= BUSY;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    k     <= 2'd0;
                end
                default: begin
                    state <= IDLE;
                    k     <= 2'd0;
                end
            endcase
        end
    end

endmodule
